// File: rtl/can_bit_timing.sv
// CAN receive bit timing: synchronises the bus line, produces one sample strobe
// per nominal bit and applies hard sync / SJW-limited resync on falling edges.
module can_bit_timing #(
  parameter int BRP        = 4,
  parameter int PROP_SEG   = 2,
  parameter int PHASE_SEG1 = 3,
  parameter int PHASE_SEG2 = 3,
  parameter int SJW        = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic canRX,
  input  logic hardSyncEnable,
  output logic samplePoint,
  output logic sampledBit,
  output logic txPoint,
  output logic resyncDone
);

  localparam int PW = 6;
  localparam int TW = 5;
  localparam logic [PW-1:0] PRESC_LAST = PW'(BRP - 1);
  localparam logic [TW-1:0] SEG1_NOM   = TW'(PROP_SEG + PHASE_SEG1);
  localparam logic [TW-1:0] SEG2_NOM   = TW'(PHASE_SEG2);
  localparam logic [TW-1:0] SJW_TQ     = TW'(SJW);
  localparam logic [TW-1:0] ONE_TQ     = TW'(1);

  typedef enum logic [1:0] {SYNC, TSEG1, TSEG2} segState_t;

  logic            rxMeta, rxs, rxsPrev;
  segState_t       stateReg, stateNext, effState;
  logic [PW-1:0]   prescReg, prescNext, effPresc;
  logic [TW-1:0]   tqReg, tqNext, effTq;
  logic [TW-1:0]   seg1Reg, seg1Next, seg1Base, seg1Eff;
  logic [TW-1:0]   seg2Reg, seg2Next, seg2Base, seg2Eff, seg2Short;
  logic [TW-1:0]   posJump, negJump, remTq;
  logic            syncLockReg, syncLockNext;
  logic            sampledBitReg, resyncDoneReg;
  logic            fallEdge, hardSync, resyncOk, posResync, negResync;
  logic            tqEnd, sampleNow;

  always_comb begin
    fallEdge  = rxsPrev & ~rxs;
    hardSync  = fallEdge & hardSyncEnable & ~syncLockReg;
    resyncOk  = fallEdge & ~hardSyncEnable & ~syncLockReg & sampledBitReg;
    posResync = resyncOk && (stateReg == TSEG1);
    negResync = resyncOk && (stateReg == TSEG2);

    // A hard sync turns the current clock into the first clock of SYNC.
    effState = hardSync ? SYNC     : stateReg;
    effPresc = hardSync ? '0       : prescReg;
    effTq    = hardSync ? '0       : tqReg;
    seg1Base = hardSync ? SEG1_NOM : seg1Reg;
    seg2Base = hardSync ? SEG2_NOM : seg2Reg;
    tqEnd    = (effPresc == PRESC_LAST);

    posJump = ((effTq + ONE_TQ) < SJW_TQ) ? (effTq + ONE_TQ) : SJW_TQ;
    seg1Eff = posResync ? (seg1Base + posJump) : seg1Base;

    // Shortening never ends the bit before the end of the tq already in progress.
    remTq     = seg2Base - effTq;
    negJump   = (remTq < SJW_TQ) ? remTq : SJW_TQ;
    seg2Short = seg2Base - negJump;
    if (!negResync)
      seg2Eff = seg2Base;
    else if (seg2Short > effTq)
      seg2Eff = seg2Short;
    else
      seg2Eff = effTq + ONE_TQ;

    stateNext    = effState;
    prescNext    = tqEnd ? '0 : effPresc + PW'(1);
    tqNext       = effTq;
    seg1Next     = seg1Eff;
    seg2Next     = seg2Eff;
    syncLockNext = syncLockReg | hardSync | posResync | negResync;
    sampleNow    = 1'b0;

    case (effState)
      SYNC: begin
        if (tqEnd) begin
          stateNext = TSEG1;
          tqNext    = '0;
        end
      end
      TSEG1: begin
        if (tqEnd) begin
          if (effTq == seg1Eff - ONE_TQ) begin
            stateNext = TSEG2;
            tqNext    = '0;
            sampleNow = 1'b1;
          end else begin
            tqNext = effTq + ONE_TQ;
          end
        end
      end
      TSEG2: begin
        if (tqEnd) begin
          if (effTq >= seg2Eff - ONE_TQ) begin
            stateNext    = SYNC;
            tqNext       = '0;
            seg1Next     = SEG1_NOM;
            seg2Next     = SEG2_NOM;
            syncLockNext = 1'b0;
          end else begin
            tqNext = effTq + ONE_TQ;
          end
        end
      end
      default: begin
        stateNext = SYNC;
        tqNext    = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rxMeta        <= 1'b1;
      rxs           <= 1'b1;
      rxsPrev       <= 1'b1;
      stateReg      <= SYNC;
      prescReg      <= '0;
      tqReg         <= '0;
      seg1Reg       <= SEG1_NOM;
      seg2Reg       <= SEG2_NOM;
      syncLockReg   <= 1'b0;
      sampledBitReg <= 1'b1;
      resyncDoneReg <= 1'b0;
    end else begin
      rxMeta        <= canRX;
      rxs           <= rxMeta;
      rxsPrev       <= rxs;
      stateReg      <= stateNext;
      prescReg      <= prescNext;
      tqReg         <= tqNext;
      seg1Reg       <= seg1Next;
      seg2Reg       <= seg2Next;
      syncLockReg   <= syncLockNext;
      resyncDoneReg <= posResync | negResync;
      if (sampleNow)
        sampledBitReg <= rxs;
    end
  end

  // Strobes are decoded from the live counters, so they are masked while in reset.
  assign samplePoint = ~reset & sampleNow;
  assign txPoint     = ~reset & (effState == SYNC) & (effPresc == '0);
  assign resyncDone  = ~reset & (hardSync | resyncDoneReg);
  assign sampledBit  = sampledBitReg;

endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing with default timing (36 clocks per bit).
module tb_can_bit_timing;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic canRX = 1'b1;
  logic hardSyncEnable = 1'b0;
  logic samplePoint, sampledBit, txPoint, resyncDone;

  int cyc = 0;
  int base = 0;
  int compared = 0;
  int mismatched = 0;
  int txLog[$];
  int spLog[$];
  int rdLog[$];

  int expTx[12] = '{0, 36, 72, 108, 148, 180, 216, 252, 260, 296, 325, 361};
  int expSp[10] = '{23, 59, 95, 135, 171, 203, 239, 283, 319, 348};
  int expRd[3]  = '{118, 177, 260};

  can_bit_timing dut (
    .clock(clock),
    .reset(reset),
    .canRX(canRX),
    .hardSyncEnable(hardSyncEnable),
    .samplePoint(samplePoint),
    .sampledBit(sampledBit),
    .txPoint(txPoint),
    .resyncDone(resyncDone)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (txPoint !== 1'b0) begin
      txLog.push_back(cyc - base);
      $display("txPoint     cycle %0d", cyc - base);
    end
    if (samplePoint !== 1'b0) begin
      spLog.push_back(cyc - base);
      $display("samplePoint cycle %0d rxs sampled", cyc - base);
    end
    if (resyncDone !== 1'b0) begin
      rdLog.push_back(cyc - base);
      $display("resyncDone  cycle %0d", cyc - base);
    end
  end

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns #1 after the falling edge of relative cycle n.
  task automatic goto(input int n);
    while (cyc - base < n) @(negedge clock);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    checkValue("resetSamplePoint", samplePoint, 0);
    checkValue("resetTxPoint", txPoint, 0);
    checkValue("resetResyncDone", resyncDone, 0);
    checkValue("resetSampledBit", sampledBit, 1);

    @(posedge clock);
    #1;
    reset = 1'b0;
    base = cyc;

    // Idle bus for three bits.
    goto(96);
    checkValue("idleSampledBit", sampledBit, 1);
    checkValue("idleNoResync", rdLog.size(), 0);

    // Positive phase error: edge detected at 117, second tq of TSEG1.
    goto(115); canRX = 1'b0;
    goto(120); canRX = 1'b1;
    goto(136);
    checkValue("posResyncSampledBit", sampledBit, 1);

    // Negative phase error at 176 (r=2), then a second edge at 178.
    goto(174); canRX = 1'b0;
    goto(175); canRX = 1'b1;
    goto(176); canRX = 1'b0;
    goto(177); canRX = 1'b1;

    // Edge in SYNC (181): ignored, and the bit samples dominant.
    goto(179); canRX = 1'b0;
    goto(204);
    checkValue("syncEdgeSampledBit", sampledBit, 0);

    // Edge in TSEG1 at 225 while last sample was dominant: no resync.
    goto(205); canRX = 1'b1;
    goto(223); canRX = 1'b0;
    goto(240);
    checkValue("dominantSampledBit", sampledBit, 0);

    // Hard sync at 260, then a locked-out edge at 266.
    goto(241); canRX = 1'b1; hardSyncEnable = 1'b1;
    goto(258); canRX = 1'b0;
    goto(262); canRX = 1'b1;
    goto(264); canRX = 1'b0;
    goto(284);
    checkValue("hardSyncSampledBit", sampledBit, 0);
    goto(321);
    checkValue("preResetSampledBit", sampledBit, 0);
    canRX = 1'b1;

    // Reset for three clocks in the middle of TSEG2.
    goto(322); reset = 1'b1;
    goto(324);
    checkValue("midResetSamplePoint", samplePoint, 0);
    checkValue("midResetTxPoint", txPoint, 0);
    checkValue("midResetResyncDone", resyncDone, 0);
    checkValue("midResetSampledBit", sampledBit, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    goto(349);
    checkValue("postResetSampledBit", sampledBit, 1);
    goto(365);

    checkValue("txCount", txLog.size(), 12);
    for (int i = 0; i < 12; i++)
      checkValue($sformatf("tx[%0d]", i), (i < txLog.size()) ? txLog[i] : -1, expTx[i]);
    checkValue("spCount", spLog.size(), 10);
    for (int i = 0; i < 10; i++)
      checkValue($sformatf("sp[%0d]", i), (i < spLog.size()) ? spLog[i] : -1, expSp[i]);
    checkValue("rdCount", rdLog.size(), 3);
    for (int i = 0; i < 3; i++)
      checkValue($sformatf("rd[%0d]", i), (i < rdLog.size()) ? rdLog[i] : -1, expRd[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
Bit-timing and sampling stage for the CAN receive path. It sits directly upstream of the frame maker. It turns the raw bus line into a synchronised bit stream: one samplePoint strobe per nominal bit, plus the bit value captured at that strobe. It performs CAN hard synchronisation and resynchronisation (SJW-limited phase correction) on recessive-to-dominant edges.

Parameters:
BRP, 4, system clocks per time quantum (tq); legal range 1..64
PROP_SEG, 2, propagation segment length in tq; legal range 1..8
PHASE_SEG1, 3, phase segment 1 length in tq; legal range 1..8
PHASE_SEG2, 3, phase segment 2 length in tq; legal range 2..8
SJW, 1, resync jump width in tq; legal range 1..4, and SJW <= PHASE_SEG2

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
canRX  input  1  raw bus line, asynchronous (1 = recessive)
hardSyncEnable  input  1  high while the bus is idle or in intermission; arms hard sync
samplePoint  output  1  one-clock pulse at the sample point of each bit
sampledBit  output  1  canRX value captured at the last samplePoint
txPoint  output  1  one-clock pulse at the first clock of each SYNC segment
resyncDone  output  1  one-clock pulse when a resync or hard sync is applied (debug/verification)

Behaviour:
- Input conditioning:
  - canRX passes through a 2-flop synchroniser, giving rxs.
  - Edge = rxs_prev 1 -> rxs 0, detected at clock rate.
  - Fixed latency of 2 clocks from pin to detection.
- Prescaler:
  - Counts 0..BRP-1; a tq ends on the cycle where the count equals BRP-1.
  - Free-running; cleared only by hard sync or reset.
- States: SYNC (1 tq), TSEG1 (PROP_SEG+PHASE_SEG1 tq, plus any lengthening), TSEG2 (PHASE_SEG2 tq, minus any shortening).
- Transitions: SYNC -> TSEG1 -> TSEG2 -> SYNC, each at the end of the last tq of the segment.
- Strobes:
  - txPoint = first clock of SYNC.
  - samplePoint = last clock of TSEG1; at that clock sampledBit <= rxs.
  - With defaults: SYNC starts at clock s; samplePoint at s+23; next SYNC at s+36.
- Hard sync (priority over resync):
  - Trigger: edge while hardSyncEnable = 1, in any state.
  - Action: prescaler := 0, state := SYNC at that same clock, txPoint pulses, resyncDone pulses.
  - After a hard sync, no further sync is allowed until the next SYNC.
- Resync (hardSyncEnable = 0):
  - At most one resync per bit.
  - Only allowed if sampledBit = 1 (recessive).
  - Edge in SYNC: no action.
  - Edge in TSEG1 (positive phase error): e = tq index within TSEG1, counting from 1. TSEG1 is lengthened by min(e, SJW) tq, which moves samplePoint later.
  - Edge in TSEG2 (negative phase error): r = remaining TSEG2 tq including the current one. TSEG2 is shortened by min(r, SJW) tq. If the shortening consumes r, the bit ends at the end of the current tq.
  - resyncDone pulses one clock after detection.
- Lengthening and shortening apply to the current bit only. Segment lengths return to nominal at the next SYNC.
- Reset:
  - State SYNC; prescaler and segment counters 0.
  - Synchroniser flops and rxs_prev = 1.
  - sampledBit = 1; samplePoint, txPoint, resyncDone = 0.
  - Reset asserted mid-bit aborts the bit. The first txPoint after release is on the first clock after reset deasserts.
- Counter width: sized for max (16+4) tq and BRP 64. No wrap is possible within legal parameters.

Test Plan:
- Idle bus, canRX held 1, defaults, reset released at cycle 0 -> txPoint at 0, 36, 72…; samplePoint at 23, 59, 95…; sampledBit stays 1; resyncDone never pulses.
- Hard sync: hardSyncEnable=1, canRX 1->0 at cycle t (mid-TSEG1) -> txPoint and resyncDone at t+2; samplePoint at t+25 with sampledBit=0.
- Positive resync: hardSyncEnable=0, previous sampledBit=1, edge detected 2 tq into TSEG1 -> samplePoint at s+27 instead of s+23; next txPoint at s+40.
- Negative resync: edge detected in 2nd tq of TSEG2 (r=2) -> next txPoint at s+32 instead of s+36; a second edge in the same bit produces no adjustment.
- Previous sampledBit=0 and an edge in TSEG1 -> no resync; samplePoint stays at s+23; resyncDone stays low.
- Reset held for 3 cycles mid-TSEG2 -> all outputs return to reset values; txPoint on the first cycle after release; samplePoint 23 cycles later.
